paralelo_serial: RTL

PARALELO_SERIAL -- requirements
Module: paralelo_serial

---
 rtl/paralelo_serial_pkg.sv | 20 ++
 rtl/paralelo_serial_fifo_2x8.sv | 58 +++++
 rtl/paralelo_serial.sv | 128 ++++++++++++
 3 files changed

// File: rtl/paralelo_serial_pkg.sv
// paralelo_serial_pkg
//   Shared constants and types for the parallel-to-serial line driver:
//   byte width, default idle/comma byte, default length of the post-reset
//   idle sequence, and the FSM state encoding.
package paralelo_serial_pkg;

  localparam int BYTE_W    = 8;
  localparam int BIT_CNT_W = $clog2(BYTE_W);

  typedef logic [BYTE_W-1:0] byte_t;

  localparam byte_t IDLE_BYTE_DEF = 8'hBC;
  localparam int    INIT_IDLE_DEF = 4;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/paralelo_serial_fifo_2x8.sv
// fifo_2x8
//   Two-entry byte FIFO feeding the serializer.
//   Ports:
//     clk_8f  - bit-rate clock, rising edge
//     reset   - asynchronous, active-high
//     push    - write din at this edge (ignored when full)
//     pop     - advance head at this edge (ignored when empty)
//     din     - byte to write
//     dout    - current head byte (valid when count != 0)
//     count   - number of stored bytes, 0..2
//   A simultaneous push and pop with one entry stored keeps count at 1 and
//   the pushed byte becomes the new head.
module fifo_2x8
  import paralelo_serial_pkg::*;
(
  input  logic        clk_8f,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  byte_t       din,
  output byte_t       dout,
  output logic [1:0]  count
);

  byte_t mem [2];
  logic  rd_ptr;
  logic  wr_ptr;
  logic  do_push;
  logic  do_pop;

  assign do_push = push && (count != 2'd2);
  assign do_pop  = pop  && (count != 2'd0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/paralelo_serial.sv
// paralelo_serial
//   Byte-to-serial line driver. Bytes from the upstream mux are buffered in
//   a 2-entry FIFO and shifted out MSB first, one bit per clk_8f cycle.
//   When nothing is buffered at a byte boundary the idle/comma byte is sent
//   instead, so the line never carries partial bytes. After reset the line
//   carries INIT_IDLE idle bytes (the reset preload included) before any
//   buffered data.
//   Ports:
//     clk_8f     - bit-rate clock (8x byte rate), rising edge
//     reset      - asynchronous, active-high
//     data_in    - byte from upstream
//     valid_in   - data_in holds a byte this cycle
//     ready_out  - combinational, FIFO has room (count < 2)
//     data_out   - registered serial line
//     active_out - registered, current data_out bit belongs to a data byte
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_INIT | post-reset idle sequence, every load is IDLE_BYTE, no pops
//   ST_RUN  | normal operation, loads pop the FIFO head when available
module paralelo_serial
  import paralelo_serial_pkg::*;
#(
  parameter byte_t IDLE_BYTE = IDLE_BYTE_DEF,
  parameter int    INIT_IDLE = INIT_IDLE_DEF
) (
  input  logic              clk_8f,
  input  logic              reset,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              data_out,
  output logic              active_out
);

  localparam int IDLE_CNT_W = (INIT_IDLE > 2) ? $clog2(INIT_IDLE) : 1;

  // The preload counts as the first idle byte, so the last INIT load is the
  // one that sees idle_cnt == INIT_IDLE-2 and leaves it at INIT_IDLE-1; the
  // following load is then already in RUN. With INIT_IDLE <= 1 the preload
  // alone satisfies the sequence and the block starts directly in RUN.
  localparam logic [IDLE_CNT_W-1:0] IDLE_LAST =
    IDLE_CNT_W'((INIT_IDLE > 1) ? (INIT_IDLE - 2) : 0);
  localparam state_t RST_STATE = (INIT_IDLE > 1) ? ST_INIT : ST_RUN;

  state_t                  state_q;
  state_t                  state_d;
  logic [IDLE_CNT_W-1:0]   idle_cnt_q;
  logic [IDLE_CNT_W-1:0]   idle_cnt_d;
  logic [BIT_CNT_W-1:0]    bit_cnt;
  byte_t                   shreg;
  logic                    is_data;

  logic                    load;
  logic                    take_fifo;
  logic                    push;
  byte_t                   fifo_dout;
  logic [1:0]              fifo_count;

  assign ready_out = (fifo_count != 2'd2);
  assign push      = valid_in && ready_out;
  assign load      = (bit_cnt == BIT_CNT_W'(BYTE_W - 1));

  fifo_2x8 u_fifo (
    .clk_8f (clk_8f),
    .reset  (reset),
    .push   (push),
    .pop    (take_fifo),
    .din    (data_in),
    .dout   (fifo_dout),
    .count  (fifo_count)
  );

  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      state_q    <= RST_STATE;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    take_fifo  = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (load) begin
          idle_cnt_d = idle_cnt_q + IDLE_CNT_W'(1);
          if (idle_cnt_q == IDLE_LAST) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        take_fifo = load && (fifo_count != 2'd0);
      end
      default: begin
        state_d = RST_STATE;
      end
    endcase
  end

  // data_out/active_out lag shreg/is_data by one edge, so a byte loaded at
  // the bit_cnt=7 edge shows its MSB on the line at the next edge.
  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      data_out   <= 1'b0;
      active_out <= 1'b0;
      shreg      <= IDLE_BYTE;
      is_data    <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      data_out   <= shreg[BYTE_W-1];
      active_out <= is_data;
      bit_cnt    <= bit_cnt + BIT_CNT_W'(1);
      if (load) begin
        shreg   <= take_fifo ? fifo_dout : IDLE_BYTE;
        is_data <= take_fifo;
      end else begin
        shreg   <= {shreg[BYTE_W-2:0], 1'b0};
      end
    end
  end

endmodule
